// File: rtl/beamform_pkg.sv
// Shared constants and types for the beamforming delay path.
// This covers the sum-of-squares producer and the square-root consumer.
package beamform_pkg;
  localparam int W_IN  = 16;
  localparam int W_OUT = 2 * W_IN;
  localparam int W_CNT = $clog2(W_IN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_X = 3'd1,
    MUL_Y = 3'd2,
    DONE  = 3'd3
  } state_t;

  // Square-root stage states live here so producer and consumer agree on one definition.
  localparam logic [1:0] SQRT_IDLE = 2'd0;
  localparam logic [1:0] SQRT_CALC = 2'd1;
  localparam logic [1:0] SQRT_DONE = 2'd2;

  // |v| as unsigned; -32768 maps to 0x8000, which is the correct magnitude.
  function automatic logic [W_IN-1:0] mag_of(input logic signed [W_IN-1:0] v);
    return v[W_IN-1] ? $unsigned(-v) : $unsigned(v);
  endfunction
endpackage

// File: rtl/shift_add_step.sv
// One shift-add multiplier iteration: acc + (mag[i] ? mag << i : 0).
module shift_add_step
  import beamform_pkg::*;
(
  input  logic [W_OUT-1:0] acc,
  input  logic [W_IN-1:0]  mag,
  input  logic [W_CNT-1:0] i,
  output logic [W_OUT-1:0] acc_next
);
  logic [W_OUT-1:0] part;

  assign part     = mag[i] ? ({{(W_OUT-W_IN){1'b0}}, mag} << i) : '0;
  assign acc_next = acc + part;
endmodule

// File: rtl/sum_sq_seq.sv
// Sequential x^2 + z^2 for the beamforming delay path, one partial product per cycle.
// The result is handed to the square-root stage with a valid/ack handshake.
module sum_sq_seq
  import beamform_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic signed [W_IN-1:0] x,
  input  logic signed [W_IN-1:0] z,
  input  logic                   ack,
  output logic [W_OUT-1:0]       dout,
  output logic                   valid,
  output logic                   busy,
  output logic [2:0]             cstate
);
  state_t           state;
  logic [W_OUT-1:0] acc, acc_next;
  logic [W_IN-1:0]  mag, mag_z;
  logic [W_CNT-1:0] i;
  logic             last;

  shift_add_step u_step (
    .acc      (acc),
    .mag      (mag),
    .i        (i),
    .acc_next (acc_next)
  );

  assign last   = (i == W_CNT'(W_IN - 1));
  assign cstate = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      mag   <= '0;
      mag_z <= '0;
      i     <= '0;
      dout  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mag   <= mag_of(x);
          mag_z <= mag_of(z);
          acc   <= '0;
          i     <= '0;
          busy  <= 1'b1;
          state <= MUL_X;
        end
        MUL_X: begin
          acc <= acc_next;
          i   <= i + 1'b1;
          if (last) begin
            mag   <= mag_z;
            state <= MUL_Y;
          end
        end
        MUL_Y: begin
          acc <= acc_next;
          i   <= i + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Publish on the first DONE cycle; ack is honoured only once valid is up.
          if (!valid) begin
            dout  <= acc;
            valid <= 1'b1;
          end else if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sum_sq_seq.md
# sum_sq_seq

Sequential sum-of-squares unit for the beamforming delay path. It computes dout = x² + z² from two signed 16-bit coordinate offsets using an iterative shift-add multiplier, one partial product per cycle. It is the producer that feeds the square-root stage: its 32-bit dout drives that stage's 32-bit operand input, and its start/valid handshake matches that stage's enable/valid handshake.

## Interface
Parameters:
- W_IN, 16: signed input width; fixed at 16 for this revision.
- W_OUT, 32: output width, equal to 2·W_IN.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a computation; sampled only in IDLE.
- x, input, 16: signed lateral offset; captured when start is accepted.
- z, input, 16: signed axial offset; captured when start is accepted.
- ack, input, 1: consumer has taken dout; sampled only in DONE.
- dout, output, 32: unsigned x² + z².
- valid, output, 1: dout is valid.
- busy, output, 1: high in MUL_X and MUL_Y.
- cstate, output, 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, MUL_X=1, MUL_Y=2, DONE=3. Encodings 4–7 are illegal and go to IDLE on the next edge.
- IDLE, start=1:
  - Latch mag = |x| as an unsigned 16-bit value. |−32768| = 32768 is representable.
  - Latch the unsigned magnitude |z| for later use.
  - Clear acc and the iteration counter i; go to MUL_X.
- IDLE, start=0: hold all state; valid=0.
- MUL_X, 16 iterations (i = 0..15):
  - If bit i of mag is 1, acc += mag << i. acc is 32 bits and never overflows, because max |x|² = 2^30.
  - i increments each cycle.
  - At i=15, i resets to 0, mag is reloaded with |z|, and the state goes to MUL_Y.
- MUL_Y, 16 iterations: same shift-add with |z|, accumulating into the same acc. At i=15 go to DONE.
- DONE:
  - On entry edge: dout ← acc, valid ← 1.
  - Hold dout and valid while ack=0.
  - ack=1: go to IDLE; valid clears on that same edge.
- start is ignored outside IDLE; there is no queueing.
- ack is ignored outside DONE.
- Maximum result: x = z = −32768 gives 0x8000_0000. It fits unsigned 32 bits, so no saturation is needed.

## Timing
- Reset (asynchronous assert, synchronous deassert at system level):
  - state = IDLE; dout = 0, valid = 0, busy = 0, cstate = 0.
  - acc, mag and i are cleared.
- Latency: start sampled at edge k → MUL_X from k through k+16 → MUL_Y through k+32 → valid=1 and dout stable after edge k+33.
- busy is high from after edge k until edge k+32; it is registered and follows the state.
- Back-to-back operation:
  - ack high at edge m returns to IDLE.
  - start can be accepted at edge m+1.
  - Minimum period is 35 cycles with ack held high.
- ack already high on entry to DONE: valid is high for exactly one cycle.
- reset_n low mid-computation: immediate return to IDLE with all outputs cleared; the partial result is discarded.
- x and z may change after the accept edge without effect.

## Structure
- Shared package beamform_pkg holds:
  - State localparams IDLE, MUL_X, MUL_Y, DONE.
  - W_IN and W_OUT constants.
  - The sqrt-stage state constants, so both ends share one definition.
- One natural sub-module: shift_add_step. It is combinational: inputs acc, mag and i; output acc + (mag[i] ? mag << i : 0). It is instantiated once and reused for both operands.
- FSM, counter and registers live in sum_sq_seq. Expected size is about 150–200 lines in total.

## Test plan
- x=3, z=4, start pulsed one cycle → dout=25, valid rises exactly 33 cycles after the accept edge; busy high for 32 cycles.
- x=−32768, z=−32768 → dout=0x8000_0000. Also x=32767, z=0 → 0x3FFF_0001. Also x=0, z=0 → 0.
- start re-pulsed with x=100 during MUL_Y of the (3,4) computation → result is still 25, and no second computation starts.
- ack held low for 10 cycles in DONE → valid and dout stable throughout. ack=1 → valid=0 next cycle, state returns to IDLE.
- reset_n pulsed low at cycle 20 of a computation → cstate=0, valid=0, dout=0 immediately. A following computation with x=−5, z=12 gives 169.
- 200 random signed (x, z) pairs streamed with ack tied high → every dout matches the reference x²+z², with a 35-cycle period.
